hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage load-use stall unit.
- Replaces the single "previous rd was a load" compare with a per-register countdown scoreboard. This covers multi-cycle loads, a long-latency mult/div unit, WAW hazards and structural mult/div busy.
- Sits in decode, between the instruction decoder and the decode/execute pipeline register.
- Drives the stall and squash controls that zero the execute-stage enables.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard scoreboard bus.
// Carries the decoded instruction fields from the decoder into the scoreboard,
// and carries the stall/squash/issue controls and status back out.
//   master : decoder side (drives the issue fields and flush, observes the controls)
//   slave  : scoreboard side (observes the issue fields, drives the controls)
interface hazard_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned STAT_W     = 16
);
  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_rd_we;
  logic                  issue_is_load;
  logic                  issue_is_md;
  logic [REG_ADDR_W-1:0] src_a;
  logic [REG_ADDR_W-1:0] src_b;
  logic                  src_a_used;
  logic                  src_b_used;
  logic                  flush;

  logic                  stall;
  logic                  squash;
  logic                  issue_fire;
  logic [NUM_REGS-1:0]   pending;
  logic                  md_busy;
  logic [STAT_W-1:0]     stall_count;

  modport master (
    output issue_valid, issue_rd, issue_rd_we, issue_is_load, issue_is_md,
           src_a, src_b, src_a_used, src_b_used, flush,
    input  stall, squash, issue_fire, pending, md_busy, stall_count
  );

  modport slave (
    input  issue_valid, issue_rd, issue_rd_we, issue_is_load, issue_is_md,
           src_a, src_b, src_a_used, src_b_used, flush,
    output stall, squash, issue_fire, pending, md_busy, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for the decode stage.
// Each architectural register has a counter holding the number of cycles until
// its in-flight result can be consumed; a separate counter tracks mult/div
// unit occupancy. Decode stalls on RAW, WAW and structural mult/div hazards,
// and a redirect (flush) squashes the decode instruction instead of stalling.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   sb      : scoreboard bus (slave) -- issue fields and flush in,
//             stall/squash/issue_fire/pending/md_busy/stall_count out
module hazard_scoreboard #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MD_LAT     = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  hazard_scoreboard_if.slave sb
);
  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_W;

  // Entry 0 exists only to keep indexing uniform; it is held at zero.
  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [CNT_W-1:0]    r_md_cnt;
  logic [STAT_W-1:0]   r_stall_cnt;

  logic [NUM_REGS-1:0] w_pending;
  logic                w_md_busy;
  logic                w_hz;
  logic                w_fire;
  logic                w_sb_write;
  logic [CNT_W-1:0]    w_sb_lat;

  always_comb begin
    w_pending = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_pending[r] = (r_cnt[r] != '0);
    end
  end

  assign w_md_busy = (r_md_cnt != '0);

  // pending[0] is constant 0, so r0 reads/writes never create a hazard.
  assign w_hz = sb.issue_valid &
                ((sb.src_a_used  & w_pending[sb.src_a])   |
                 (sb.src_b_used  & w_pending[sb.src_b])   |
                 (sb.issue_rd_we & w_pending[sb.issue_rd]) |
                 (sb.issue_is_md & w_md_busy));

  assign w_fire = sb.issue_valid & ~w_hz & ~sb.flush;

  // Only loads and mult/div leave a scoreboard entry; ALU results are forwarded.
  assign w_sb_write = w_fire & sb.issue_rd_we & (sb.issue_rd != '0) &
                      (sb.issue_is_load | sb.issue_is_md);
  // Mult/div takes priority when both type flags are set.
  assign w_sb_lat   = sb.issue_is_md ? CNT_W'(MD_LAT) : CNT_W'(LOAD_LAT);

  // The WAW term guarantees a written counter is already zero, so the new
  // latency simply replaces the (idle) decrement for that entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (w_sb_write && (sb.issue_rd == REG_ADDR_W'(r))) begin
          r_cnt[r] <= w_sb_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
    end
  end

  // Unit occupancy is claimed by every issued mult/div, even one targeting r0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt <= '0;
    end else if (w_fire && sb.issue_is_md) begin
      r_md_cnt <= CNT_W'(MD_LAT);
    end else if (w_md_busy) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (sb.stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end

  assign sb.stall       = w_hz & ~sb.flush;
  assign sb.squash      = w_hz | sb.flush;
  assign sb.issue_fire  = w_fire;
  assign sb.pending     = w_pending;
  assign sb.md_busy     = w_md_busy;
  assign sb.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance with LOAD_LAT=1 (dut)
// and one with LOAD_LAT=3 (dut3), both MD_LAT=32.
module tb_hazard_scoreboard;
  logic clock;
  logic reset_n;

  int unsigned n_cmp;
  int unsigned n_err;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .STAT_W(16)) ifa ();
  hazard_scoreboard_if #(.REG_ADDR_W(5), .STAT_W(16)) ifb ();

  hazard_scoreboard #(
    .REG_ADDR_W(5), .LOAD_LAT(1), .MD_LAT(32), .CNT_W(6), .STAT_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sb(ifa)
  );

  hazard_scoreboard #(
    .REG_ADDR_W(5), .LOAD_LAT(3), .MD_LAT(32), .CNT_W(6), .STAT_W(16)
  ) dut3 (
    .clock(clock), .reset_n(reset_n), .sb(ifb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 -> dut (ifa), 1 -> dut3 (ifb)
  task automatic drv(input int which, input logic v, input logic [4:0] rd,
                     input logic we, input logic ld, input logic md,
                     input logic [4:0] a, input logic [4:0] b,
                     input logic au, input logic bu, input logic fl);
    if (which == 0) begin
      ifa.issue_valid = v; ifa.issue_rd = rd; ifa.issue_rd_we = we;
      ifa.issue_is_load = ld; ifa.issue_is_md = md; ifa.src_a = a; ifa.src_b = b;
      ifa.src_a_used = au; ifa.src_b_used = bu; ifa.flush = fl;
    end else begin
      ifb.issue_valid = v; ifb.issue_rd = rd; ifb.issue_rd_we = we;
      ifb.issue_is_load = ld; ifb.issue_is_md = md; ifb.src_a = a; ifb.src_b = b;
      ifb.src_a_used = au; ifb.src_b_used = bu; ifb.flush = fl;
    end
  endtask

  task automatic idle(input int which);
    drv(which, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle(0);
    idle(1);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("rst_pending", 64'(ifa.pending), 64'h0);
    chk("rst_md_busy", 64'(ifa.md_busy), 64'h0);
    chk("rst_stall_count", 64'(ifa.stall_count), 64'h0);
    chk("rst_stall", 64'(ifa.stall), 64'h0);
    step();

    // load r5, then add r6,r5,r1 (LOAD_LAT=1)
    drv(0, 1, 5'd5, 1, 1, 0, 5'd2, 5'd0, 1, 0, 0); #1;
    chk("t1_load_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd6, 1, 0, 0, 5'd5, 5'd1, 1, 1, 0); #1;
    chk("t1_stall", 64'(ifa.stall), 64'h1);
    chk("t1_squash", 64'(ifa.squash), 64'h1);
    chk("t1_nofire", 64'(ifa.issue_fire), 64'h0);
    chk("t1_pending5", 64'(ifa.pending), 64'h20);
    step();
    chk("t1_fire", 64'(ifa.issue_fire), 64'h1);
    chk("t1_stall_rel", 64'(ifa.stall), 64'h0);
    chk("t1_pending_clr", 64'(ifa.pending), 64'h0);
    chk("t1_stall_count", 64'(ifa.stall_count), 64'h1);
    step();
    idle(0);

    // LOAD_LAT=3: load r7, independent add, consumer of r7 stalls 2 cycles
    drv(1, 1, 5'd7, 1, 1, 0, 5'd2, 5'd0, 1, 0, 0); #1;
    chk("t2_load_fire", 64'(ifb.issue_fire), 64'h1);
    step();
    drv(1, 1, 5'd10, 1, 0, 0, 5'd1, 5'd2, 1, 1, 0); #1;
    chk("t2_indep_fire", 64'(ifb.issue_fire), 64'h1);
    step();
    drv(1, 1, 5'd11, 1, 0, 0, 5'd7, 5'd0, 1, 1, 0); #1;
    chk("t2_stall_a", 64'(ifb.stall), 64'h1);
    chk("t2_pending7", 64'(ifb.pending), 64'h80);
    step();
    chk("t2_stall_b", 64'(ifb.stall), 64'h1);
    step();
    chk("t2_fire", 64'(ifb.issue_fire), 64'h1);
    chk("t2_stall_count", 64'(ifb.stall_count), 64'h2);
    step();
    idle(1);

    // WAW: load r5 then an ALU write of r5 with no reads
    drv(0, 1, 5'd5, 1, 1, 0, 5'd0, 5'd0, 0, 0, 0); #1;
    chk("waw_load_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd5, 1, 0, 0, 5'd0, 5'd0, 0, 0, 0); #1;
    chk("waw_stall", 64'(ifa.stall), 64'h1);
    step();
    chk("waw_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    idle(0);

    // mul r8, then a second mul r11,r3,r4: structural stall of 32 cycles
    drv(0, 1, 5'd8, 1, 0, 1, 5'd1, 5'd2, 1, 1, 0); #1;
    chk("t3_mul_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd11, 1, 0, 1, 5'd3, 5'd4, 1, 1, 0); #1;
    for (int i = 0; i < 32; i++) begin
      chk("t3_md_stall", 64'(ifa.stall), 64'h1);
      step();
    end
    chk("t3_mul2_fire", 64'(ifa.issue_fire), 64'h1);
    chk("t3_md_busy_drop", 64'(ifa.md_busy), 64'h0);
    chk("t3_pending8_clr", 64'(ifa.pending), 64'h0);
    step();
    drv(0, 1, 5'd12, 1, 0, 0, 5'd11, 5'd0, 1, 0, 0); #1;
    chk("t3_raw_stall", 64'(ifa.stall), 64'h1);
    chk("t3_md_busy", 64'(ifa.md_busy), 64'h1);
    chk("t3_pending11", 64'(ifa.pending), 64'h800);
    step();
    idle(0);
    for (int i = 0; i < 35; i++) step();
    chk("t3_drained_pending", 64'(ifa.pending), 64'h0);
    chk("t3_drained_busy", 64'(ifa.md_busy), 64'h0);
    chk("t3_stall_count", 64'(ifa.stall_count), 64'd35);

    // flush in the stall cycle
    drv(0, 1, 5'd5, 1, 1, 0, 5'd0, 5'd0, 0, 0, 0); #1;
    chk("t4_load_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd6, 1, 0, 0, 5'd5, 5'd0, 1, 0, 1); #1;
    chk("t4_stall", 64'(ifa.stall), 64'h0);
    chk("t4_squash", 64'(ifa.squash), 64'h1);
    chk("t4_nofire", 64'(ifa.issue_fire), 64'h0);
    chk("t4_pending5", 64'(ifa.pending), 64'h20);
    step();
    idle(0); #1;
    chk("t4_pending_clr", 64'(ifa.pending), 64'h0);
    chk("t4_stall_count", 64'(ifa.stall_count), 64'd35);

    // load to r0, consumer of r0
    drv(0, 1, 5'd0, 1, 1, 0, 5'd0, 5'd0, 0, 0, 0); #1;
    chk("t5_load_r0_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd6, 1, 0, 0, 5'd0, 5'd0, 1, 1, 0); #1;
    chk("t5_stall", 64'(ifa.stall), 64'h0);
    chk("t5_fire", 64'(ifa.issue_fire), 64'h1);
    chk("t5_pending", 64'(ifa.pending), 64'h0);
    step();
    idle(0);

    // mul r9, asynchronous reset with md_cnt = 20
    drv(0, 1, 5'd9, 1, 0, 1, 5'd1, 5'd0, 1, 0, 0); #1;
    chk("t6_mul_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    idle(0);
    for (int i = 0; i < 12; i++) step();
    chk("t6_pre_busy", 64'(ifa.md_busy), 64'h1);
    chk("t6_pre_pending9", 64'(ifa.pending), 64'h200);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pending", 64'(ifa.pending), 64'h0);
    chk("t6_rst_busy", 64'(ifa.md_busy), 64'h0);
    chk("t6_rst_stall_count", 64'(ifa.stall_count), 64'h0);
    reset_n = 1'b1;
    step();
    drv(0, 1, 5'd6, 1, 0, 0, 5'd9, 5'd0, 1, 0, 0); #1;
    chk("t6_consumer_stall", 64'(ifa.stall), 64'h0);
    chk("t6_consumer_fire", 64'(ifa.issue_fire), 64'h1);
    step();

    // mult/div to r0 still occupies the unit
    drv(0, 1, 5'd0, 1, 0, 1, 5'd1, 5'd2, 1, 1, 0); #1;
    chk("t7_mul_r0_fire", 64'(ifa.issue_fire), 64'h1);
    step();
    drv(0, 1, 5'd13, 1, 0, 1, 5'd1, 5'd2, 1, 1, 0); #1;
    chk("t7_md_busy", 64'(ifa.md_busy), 64'h1);
    chk("t7_pending", 64'(ifa.pending), 64'h0);
    chk("t7_struct_stall", 64'(ifa.stall), 64'h1);
    step();
    idle(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
